// File: rtl/add_shift_mult_ctrl.sv
// Shift-and-add multiplier controller that time-shares one external CLA slice.
// Optional build macro SKIP_ZERO_ADD_EN: skip the ADD cycle for multiplier bits that are 0.
module add_shift_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   MCAND,
  input  logic [WIDTH-1:0]   MPLIER,
  output logic [WIDTH-1:0]   CLA_A,
  output logic [WIDTH-1:0]   CLA_B,
  output logic               CLA_CIN,
  input  logic [WIDTH-1:0]   CLA_S,
  input  logic               CLA_GG,
  input  logic               CLA_PG,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               c_q, c_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               cout;
  state_t             load_state;
  state_t             iter_state;

  assign CLA_CIN   = 1'b0;
  assign CLA_A     = acc_q;
  assign CLA_B     = m_q;
  // Carry-out rebuilt from the slice's group signals; keep the full form in case CIN is ever used.
  assign cout      = CLA_GG | (CLA_PG & CLA_CIN);
  assign BUSY      = (state_q == S_ADD) || (state_q == S_SHIFT);
  assign DONE      = (state_q == S_DONE);
  assign PRODUCT   = product_q;
  assign state_dbg = state_q;

`ifdef SKIP_ZERO_ADD_EN
  assign load_state = MPLIER[0] ? S_ADD : S_SHIFT;
  // q_q[1] is the bit that lands in q[0] after this shift.
  assign iter_state = q_q[1] ? S_ADD : S_SHIFT;
`else
  assign load_state = S_ADD;
  assign iter_state = S_ADD;
`endif

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          m_d     = MCAND;
          q_d     = MPLIER;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = load_state;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        if (q_q[0]) begin
          acc_d = CLA_S;
          c_d   = cout;
        end else begin
          c_d   = 1'b0;
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {c_d, acc_d, q_d} = {1'b0, c_q, acc_q, q_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          product_d = {acc_d, q_d};
        end else begin
          state_d   = iter_state;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_add_shift_mult_ctrl.sv
// Directed bench for add_shift_mult_ctrl with a behavioural CLA slice and a product scoreboard.
module tb_add_shift_mult_ctrl;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcand, mplier;
  logic [W-1:0]   cla_a, cla_b, cla_s;
  logic           cla_cin, cla_gg, cla_pg;
  logic           busy, done;
  logic [2*W-1:0] product;
  logic [1:0]     state_dbg;

  logic [W:0]     gen_sum;
  logic [W:0]     full_sum;

  logic [2*W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference CLA slice: generate is the carry-out with cin=0, propagate is AND of bitwise XOR.
  assign gen_sum  = {1'b0, cla_a} + {1'b0, cla_b};
  assign full_sum = gen_sum + {{W{1'b0}}, cla_cin};
  assign cla_s    = full_sum[W-1:0];
  assign cla_gg   = gen_sum[W];
  assign cla_pg   = &(cla_a ^ cla_b);

  add_shift_mult_ctrl #(.WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .START(start), .MCAND(mcand), .MPLIER(mplier),
    .CLA_A(cla_a), .CLA_B(cla_b), .CLA_CIN(cla_cin),
    .CLA_S(cla_s), .CLA_GG(cla_gg), .CLA_PG(cla_pg),
    .BUSY(busy), .DONE(done), .PRODUCT(product), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [W-1:0] mp);
`ifdef SKIP_ZERO_ADD_EN
    return W + $countones(mp);
`else
    return 2 * W + 0 * $countones(mp);
`endif
  endfunction

  function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Drive a one-cycle START; returns #1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    exp_q.push_back(mul(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for DONE; latency counts edges after the last edge before the call.
  task automatic wait_done(input string tag, input int exp_lat);
    int n = -1;
    int gaps = 0;
    logic [2*W-1:0] exp_p;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
      if (!busy) gaps++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy gaps"}, gaps, 0);
    check({tag, " busy in done"}, busy, 1'b0);
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, " product"}, product, exp_p);
  endtask

  task automatic pulse_end(input string tag);
    @(negedge clk);
    check({tag, " done pulse"}, done, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst product", product, 0);
    check("rst state", state_dbg, 0);
    check("rst cla_a", cla_a, 0);
    check("rst cla_b", cla_b, 0);
    check("rst cla_cin", cla_cin, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    issue(4'd8, 4'd7);
    check("8x7 busy after start", busy, 1'b1);
    wait_done("8x7", lat_of(4'd7));
    check("8x7 value", product, 8'h38);
    pulse_end("8x7");

    issue(4'd15, 4'd15);
    wait_done("15x15", lat_of(4'd15));
    check("15x15 value", product, 8'hE1);
    pulse_end("15x15");

    issue(4'd9, 4'd0);
    wait_done("9x0", lat_of(4'd0));
    pulse_end("9x0");

    // Back-to-back: START stays high through op A's DONE cycle, op B operands waiting.
    mcand  = 4'd6;
    mplier = 4'd3;
    start  = 1'b1;
    exp_q.push_back(mul(4'd6, 4'd3));
    @(posedge clk);
    #1;
    mcand  = 4'd5;
    mplier = 4'd10;
    exp_q.push_back(mul(4'd5, 4'd10));
    wait_done("6x3", lat_of(4'd3));
    check("6x3 value", product, 8'h12);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("5x10", lat_of(4'd10));
    check("5x10 value", product, 8'h32);
    pulse_end("5x10");

    // START during BUSY with other operands must be ignored.
    issue(4'd12, 4'd13);
    repeat (3) @(negedge clk);
    mcand  = 4'd2;
    mplier = 4'd2;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("12x13 ignore", lat_of(4'd13) - 3);
    pulse_end("12x13 ignore");

    // Reset in the 4th cycle of 13x11 discards the operation.
    issue(4'd13, 4'd11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst product", product, 0);
    check("midrst state", state_dbg, 0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    issue(4'd13, 4'd11);
    wait_done("13x11", lat_of(4'd11));
    check("13x11 value", product, 8'h8F);
    pulse_end("13x11");

    // Product register holds after DONE.
    repeat (3) @(negedge clk);
    check("hold product", product, 8'h8F);
    check("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
